// File: rtl/seq_fx_multiply.sv
// Sequential shift-add fixed-point multiplier: signed S1.14 times unsigned 2.14.
// The result is an S1.14 product, rounded half toward +inf and saturated.
// Each cycle consumes BITS_PER_CYCLE multiplier bits; no hardware multiplier is used.
// The handshake is valid/ready on both sides, and i_en is a global stall.
module seq_fx_multiply #(
   parameter int BITS_PER_CYCLE = 2     // 1, 2 or 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_result
);

   localparam int N_ITER = 16 / BITS_PER_CYCLE;
   localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic signed [33:0] a_q;        // multiplicand, pre-shifted by k*BITS_PER_CYCLE
   logic [15:0]        b_q;        // multiplier, shifted right as its bits are consumed
   logic signed [33:0] acc_q;
   logic [15:0]        result_q;
   logic signed [33:0] pp, acc_d;
   logic signed [19:0] rnd;
   logic [15:0]        sat_d;
   logic               accept, last;

   assign accept = i_valid && (state_q == S_IDLE);
   assign last   = (state_q == S_CALC) && (cnt_q == CW'(N_ITER - 1));

   // Partial product a*d for the low multiplier bits, built only from shifted copies of a.
   // The multiplicand is shifted left every cycle, so the shift by k*BITS_PER_CYCLE is already applied.
   always_comb begin
      pp = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++)
         if (b_q[j]) pp = pp + (a_q <<< j);
   end

   // Accumulate, then round (add 2^13, arithmetic shift right by 14) and saturate to 16 bits.
   always_comb begin
      acc_d = acc_q + pp;
      rnd   = 20'((acc_d + 34'sd8192) >>> 14);
      if (rnd > 20'sd32767)       sat_d = 16'h7FFF;
      else if (rnd < -20'sd32768) sat_d = 16'h8000;
      else                        sat_d = rnd[15:0];
   end

   // FSM state register; i_en low freezes it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     state_q <= S_IDLE;
      else if (i_en) state_q <= state_d;
   end

   // FSM next state: accept in IDLE, run N_ITER steps, then hold the result until it is consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)  state_d = S_CALC;
         S_CALC:  if (last)    state_d = S_DONE;
         S_DONE:  if (i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs. o_ready is low in DONE, so a new operand cannot arrive on the consume edge.
   always_comb begin
      o_ready = (state_q == S_IDLE);
      o_valid = (state_q == S_DONE);
   end

   assign o_result = result_q;

   // Datapath: capture operands on accept and step the shift-add during CALC.
   // The result register only loads on the last step.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (i_en) begin
         if (accept) begin
            a_q   <= {{18{i_a[15]}}, i_a};
            b_q   <= i_b;
            acc_q <= '0;
            cnt_q <= '0;
         end else if (state_q == S_CALC) begin
            a_q   <= a_q <<< BITS_PER_CYCLE;
            b_q   <= b_q >> BITS_PER_CYCLE;
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) result_q <= sat_d;
         end
      end
   end

endmodule

// File: tb/tb_seq_fx_multiply.sv
// Bench for seq_fx_multiply. Three instances run in lockstep with BITS_PER_CYCLE = 1, 2 and 4.
// Every instance is checked against an arithmetic golden model of the rounded, saturated product.
module tb_seq_fx_multiply;

   logic        clk = 1'b0;
   logic        rst, en, vld_in, rdy_in;
   logic [15:0] a_in, b_in;
   logic [2:0]  rdy_out, vld_out;
   logic [15:0] res [3];

   int nchk = 0;
   int nerr = 0;
   int nit [3] = '{16, 8, 4};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      seq_fx_multiply #(.BITS_PER_CYCLE(1 << g)) u_dut (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_en    (en),
         .i_valid (vld_in),
         .o_ready (rdy_out[g]),
         .i_a     (a_in),
         .i_b     (b_in),
         .o_valid (vld_out[g]),
         .i_ready (rdy_in),
         .o_result(res[g])
      );
   end

   // Golden model: exact signed*unsigned product, round half up at bit 13, then clamp.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      longint p, r;
      p = longint'($signed(a)) * longint'({16'h0, b});
      r = (p + 8192) >>> 14;
      if (r > 32767)  return 16'h7FFF;
      if (r < -32768) return 16'h8000;
      return r[15:0];
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge on idle DUTs, then scramble the inputs.
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 3; i++) chk($sformatf("ready_before[%0d]", i), rdy_out[i], 1);
      a_in = a; b_in = b; vld_in = 1'b1;
      tick();
      vld_in = 1'b0;
      a_in = 16'($urandom); b_in = 16'($urandom);
   endtask

   // Count edges since accept until each o_valid rises; compare with N_ITER + extra.
   task automatic wait_all(input int extra, input int elapsed);
      int lat [3];
      bit seen [3];
      int c;
      c = elapsed;
      for (int i = 0; i < 3; i++) begin lat[i] = -1; seen[i] = 1'b0; end
      while (!(seen[0] && seen[1] && seen[2]) && c < 60) begin
         tick();
         c++;
         for (int i = 0; i < 3; i++)
            if (!seen[i] && vld_out[i]) begin seen[i] = 1'b1; lat[i] = c; end
      end
      for (int i = 0; i < 3; i++) chk($sformatf("latency[%0d]", i), lat[i], nit[i] + extra);
   endtask

   task automatic check_consume(input logic [15:0] exp);
      for (int i = 0; i < 3; i++) chk($sformatf("result[%0d]", i), res[i], exp);
      rdy_in = 1'b1;
      tick();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("valid_after_take[%0d]", i), vld_out[i], 0);
         chk($sformatf("ready_after_take[%0d]", i), rdy_out[i], 1);
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b);
      start(a, b);
      wait_all(0, 0);
      check_consume(ref_mul(a, b));
   endtask

   initial begin
      logic [15:0] ra, rb, held;
      rst = 1'b1; en = 1'b1; vld_in = 1'b0; rdy_in = 1'b0; a_in = '0; b_in = '0;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ready[%0d]", i), rdy_out[i], 1);
         chk($sformatf("rst_valid[%0d]", i), vld_out[i], 0);
         chk($sformatf("rst_result[%0d]", i), res[i], 0);
      end
      rst = 1'b0;
      tick();

      // Directed values: check the model constants, then the DUTs.
      chk("model_half", ref_mul(16'h2000, 16'h4000), 16'h2000);
      chk("model_sat_neg", ref_mul(16'h8000, 16'hFFFF), 16'h8000);
      run_op(16'h2000, 16'h4000);
      run_op(16'hC000, 16'h8000);
      run_op(16'h6000, 16'hC000);
      run_op(16'h0001, 16'h2000);
      run_op(16'hFFFF, 16'h2000);
      run_op(16'h1234, 16'h0000);
      run_op(16'h8000, 16'hFFFF);
      run_op(16'h7FFF, 16'hFFFF);

      // Backpressure: the result holds and a second operand is ignored.
      start(16'h3000, 16'h5000);
      wait_all(0, 0);
      held = ref_mul(16'h3000, 16'h5000);
      for (int k = 0; k < 5; k++) begin
         vld_in = 1'b1; a_in = 16'h7FFF; b_in = 16'hFFFF;
         tick();
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_valid[%0d]", i), vld_out[i], 1);
            chk($sformatf("bp_ready[%0d]", i), rdy_out[i], 0);
            chk($sformatf("bp_result[%0d]", i), res[i], held);
         end
      end
      vld_in = 1'b0;
      // A stall in DONE must not complete the transfer.
      en = 1'b0; rdy_in = 1'b1;
      tick();
      rdy_in = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) chk($sformatf("stall_hold_valid[%0d]", i), vld_out[i], 1);
      check_consume(held);
      run_op(16'h0800, 16'h0300);

      // Stall mid-CALC for 3 cycles: latency grows by exactly 3.
      start(16'hA5A5, 16'h5A5A);
      tick(); tick(); tick();
      en = 1'b0;
      tick(); tick(); tick();
      en = 1'b1;
      for (int i = 0; i < 3; i++) chk($sformatf("stall_no_valid[%0d]", i), vld_out[i], 0);
      wait_all(3, 6);
      check_consume(ref_mul(16'hA5A5, 16'h5A5A));

      // Reset mid-CALC discards the operation and clears the result.
      start(16'h4000, 16'h4000);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort_valid[%0d]", i), vld_out[i], 0);
         chk($sformatf("abort_ready[%0d]", i), rdy_out[i], 1);
         chk($sformatf("abort_result[%0d]", i), res[i], 0);
      end
      tick();
      rst = 1'b0;
      tick();
      run_op(16'hE123, 16'h9876);

      // Random sweep with a bias toward the extreme operands.
      for (int n = 0; n < 2500; n++) begin
         case ($urandom_range(0, 7))
            0: ra = 16'h8000;
            1: ra = 16'h7FFF;
            2: ra = 16'hFFFF;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0: rb = 16'hFFFF;
            1: rb = 16'h0000;
            2: rb = 16'h4000;
            default: rb = 16'($urandom);
         endcase
         run_op(ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
